// File: rtl/keccak_arb_pkg.sv
// Shared types and constants for the two-requester Keccak permutation arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keccak_arb_pkg;

  localparam int WIDTH  = 1600;  // Keccak-f[1600] state width
  localparam int ROUNDS = 24;    // rounds per permutation
  localparam int NREQ   = 2;     // requesters sharing the core

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ABSORB,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; purely combinational.
// Latency: 0 cycles (grant is registered by the caller).
// Backpressure: none; the caller samples o_gnt only when it can accept an owner.
// Ports:
//   i_req  - request vector, one bit per requester
//   i_ptr  - which requester wins a tie (0 -> requester 0, 1 -> requester 1)
//   o_gnt  - one-hot grant, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    // Only a tie needs the pointer; a single requester simply wins.
    if (i_req == 2'b11) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/perm_arbiter.sv
// Shares one Keccak permutation core between two message requesters, one whole message at a time.
// Latency: request seen in IDLE at t -> core_reset at t+1 -> first core_in_ready at t+2; digest registered on core_out_ready.
// Backpressure: requester data passes straight to the core; req_ack mirrors core_ack for the owner only.
// Ports:
//   clk, reset (async, active-low)
//   req_in / req_in_ready / req_last / req_ack   - per-requester block interface (requester k on bits [k*RATE +: RATE])
//   grant / done / dout                           - owner, digest-valid pulse, registered digest
//   core_reset / core_in / core_in_ready / core_ack / core_out / core_out_ready - permutation core interface
// Optional feature: define PERM_ARB_TIMEOUT_EN to add an idle watchdog and the 'timeout' output port.
module perm_arbiter
  import keccak_arb_pkg::*;
#(
  parameter int RATE     = 576,
  parameter int DIGEST_W = 512,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*RATE-1:0]     req_in,
  input  logic [1:0]            req_in_ready,
  input  logic [1:0]            req_last,
  output logic [1:0]            req_ack,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic [DIGEST_W-1:0]   dout,
  output logic                  core_reset,
  output logic [RATE-1:0]       core_in,
  output logic                  core_in_ready,
  input  logic                  core_ack,
  input  logic [WIDTH-1:0]      core_out,
  input  logic                  core_out_ready
`ifdef PERM_ARB_TIMEOUT_EN
  ,
  output logic [1:0]            timeout
`endif
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [1:0]          r_grant;
  logic                r_ptr;         // 1 -> requester 1 wins the next tie
  logic                r_wait_first;  // first WAIT cycle: core_out_ready is stale
  logic                r_core_reset;
  logic [DIGEST_W-1:0] r_dout;
  logic [1:0]          w_arb_gnt;
  logic                w_gidx;
  logic                w_vld;
  logic                w_last;
  logic                w_abort;

  rr_arb2 u_rr_arb2 (
    .i_req (req_in_ready),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  assign w_gidx = r_grant[1];
  assign w_vld  = req_in_ready[w_gidx];
  assign w_last = req_last[w_gidx];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req_in_ready) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = ABSORB;
      ABSORB: begin
        if (w_abort)                  w_state_nxt = IDLE;
        else if (core_ack && w_last)  w_state_nxt = WAIT;
      end
      WAIT:    if (!r_wait_first && core_out_ready) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    core_in       = w_gidx ? req_in[2*RATE-1 -: RATE] : req_in[RATE-1:0];
    core_in_ready = 1'b0;
    req_ack       = 2'b00;
    done          = 2'b00;
    if (r_state == ABSORB) begin
      core_in_ready = w_vld;
      req_ack       = core_ack ? r_grant : 2'b00;
    end
    if (r_state == DONE) begin
      done = r_grant;
    end
  end

  assign grant      = r_grant;
  assign dout       = r_dout;
  assign core_reset = r_core_reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grant      <= 2'b00;
      r_ptr        <= 1'b0;
      r_wait_first <= 1'b0;
      r_core_reset <= 1'b1;  // held through the first cycle after release
      r_dout       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_reset <= (w_state_nxt == CLEAR);
      r_wait_first <= (r_state != WAIT) && (w_state_nxt == WAIT);

      if (r_state == IDLE && w_state_nxt == CLEAR) begin
        r_grant <= w_arb_gnt;
      end else if (w_state_nxt == IDLE) begin
        r_grant <= 2'b00;
      end

      if (r_state == WAIT && w_state_nxt == DONE) begin
        r_dout <= core_out[WIDTH-1 -: DIGEST_W];
      end

      // The requester just served loses the next tie.
      if (r_state == DONE || w_abort) begin
        r_ptr <= ~w_gidx;
      end
    end
  end

`ifdef PERM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_idle_cnt;
  logic [1:0]       r_timeout;

  // Abort on the TIMEOUT-th consecutive starved ABSORB cycle.
  assign w_abort = (r_state == ABSORB) && !w_vld &&
                   (r_idle_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout = r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
      r_timeout  <= 2'b00;
    end else begin
      if (r_state == ABSORB && !w_vld && !w_abort) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end else begin
        r_idle_cnt <= '0;
      end
      r_timeout <= w_abort ? r_grant : 2'b00;
    end
  end
`else
  assign w_abort = 1'b0;

  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // Only the top DIGEST_W bits of the state form the digest.
  logic w_unused_core;
  assign w_unused_core = ^core_out[WIDTH-DIGEST_W-1:0];

endmodule

// File: tb/tb_perm_arbiter.sv
`timescale 1ns/1ps
module tb_perm_arbiter;
  import keccak_arb_pkg::*;

  localparam int RATE = 576;
  localparam int DW   = 512;

  logic                clk = 1'b0;
  logic                reset;
  logic [2*RATE-1:0]   req_in;
  logic [1:0]          req_in_ready;
  logic [1:0]          req_last;
  logic [1:0]          req_ack;
  logic [1:0]          grant;
  logic [1:0]          done;
  logic [DW-1:0]       dout;
  logic                core_reset;
  logic [RATE-1:0]     core_in;
  logic                core_in_ready;
  logic                core_ack;
  logic [WIDTH-1:0]    core_out;
  logic                core_out_ready;
`ifdef PERM_ARB_TIMEOUT_EN
  logic [1:0]          timeout;
`endif

  int checks = 0;
  int failures = 0;
  int ack_cnt0 = 0, ack_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  int a0, a1, d0, d1;

  always #5 clk = ~clk;

  perm_arbiter #(.RATE(RATE), .DIGEST_W(DW), .TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_in         (req_in),
    .req_in_ready   (req_in_ready),
    .req_last       (req_last),
    .req_ack        (req_ack),
    .grant          (grant),
    .done           (done),
    .dout           (dout),
    .core_reset     (core_reset),
    .core_in        (core_in),
    .core_in_ready  (core_in_ready),
    .core_ack       (core_ack),
    .core_out       (core_out),
    .core_out_ready (core_out_ready)
`ifdef PERM_ARB_TIMEOUT_EN
    ,
    .timeout        (timeout)
`endif
  );

  always @(posedge clk) begin
    if (req_ack[0]) ack_cnt0++;
    if (req_ack[1]) ack_cnt1++;
    if (done[0])    done_cnt0++;
    if (done[1])    done_cnt1++;
  end

  function automatic logic [RATE-1:0] blk(input int k, input int b);
    logic [31:0] w;
    w = 32'hB10C_0000 | 32'(k << 8) | 32'(b);
    return {18{w}};
  endfunction

  // Expected digest: 16 distinct words so a misplaced slice shows up.
  function automatic logic [DW-1:0] dig(input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      d = {d[DW-33:0], 32'hC0DE_0000 + 32'(n * 32 + i)};
    end
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] cst(input int n);
    logic [31:0] f;
    f = ~(32'h5A5A_0000 + 32'(n));
    return {dig(n), {34{f}}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered in the CLEAR cycle of a message owned by requester k; returns in the following IDLE cycle.
  task automatic serve(input int k, input int nblk, input int n);
    logic [1:0] g;
    g = 2'b01 << k;
    chk("clear_grant", grant, g);
    chk("clear_core_reset", core_reset, 1);
    chk("clear_in_ready", core_in_ready, 0);
    tick();
    for (int b = 0; b < nblk; b++) begin
      if (b == 1) begin
        core_ack = 1'b0;
        req_in_ready[k] = 1'b0;
        #1;
        chk("stall_in_ready", core_in_ready, 0);
        chk("stall_grant", grant, g);
        tick();
      end
      req_in_ready[k] = 1'b1;
      req_last[k] = (b == nblk - 1);
      req_in[k*RATE +: RATE] = blk(k, b);
      core_ack = 1'b1;
      #1;
      chk("absorb_core_reset", core_reset, 0);
      chk("core_in", core_in, blk(k, b));
      chk("core_in_ready", core_in_ready, 1);
      chk("req_ack", req_ack, g);
      tick();
    end
    core_ack = 1'b0;
    req_in_ready[k] = 1'b0;
    req_last[k] = 1'b0;
    core_out = cst(n);
    core_out_ready = 1'b1;  // stale in the first WAIT cycle
    #1;
    chk("wait_in_ready", core_in_ready, 0);
    tick();
    chk("wait_ignore_first", done, 0);
    core_out_ready = 1'b0;
    repeat (ROUNDS - 2) tick();
    chk("wait_no_done", done, 0);
    chk("wait_grant", grant, g);
    core_out_ready = 1'b1;
    tick();
    chk("done_pulse", done, g);
    chk("dout", dout, dig(n));
    chk("done_grant", grant, g);
    core_out_ready = 1'b0;
    core_out = cst(n + 100);
    tick();
    chk("idle_done_low", done, 0);
    chk("idle_grant", grant, 0);
    chk("dout_hold", dout, dig(n));
  endtask

  initial begin
    reset = 1'b0;
    req_in = '0;
    req_in_ready = 2'b00;
    req_last = 2'b00;
    core_ack = 1'b0;
    core_out = '0;
    core_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_in_ready", core_in_ready, 0);
    chk("rst_req_ack", req_ack, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_core_reset", core_reset, 1);
    tick();
    chk("idle_core_reset", core_reset, 0);

    // Single requester 0, one block
    req_in_ready = 2'b01;
    #1;
    chk("idle_grant_zero", grant, 0);
    a0 = ack_cnt0; d0 = done_cnt0;
    tick();
    serve(0, 1, 1);
    chk("t1_acks0", ack_cnt0 - a0, 1);
    chk("t1_done0", done_cnt0 - d0, 1);

    // Simultaneous requests straight from reset: requester 0 first
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    tick();
    req_in_ready = 2'b11;
    d0 = done_cnt0; d1 = done_cnt1;
    tick();
    serve(0, 1, 2);
    tick();
    serve(1, 1, 3);
    chk("t2_done0", done_cnt0 - d0, 1);
    chk("t2_done1", done_cnt1 - d1, 1);

    // Three-block message from 0 while 1 waits; 1 was served last so 0 wins
    req_in_ready = 2'b11;
    a0 = ack_cnt0; a1 = ack_cnt1;
    tick();
    serve(0, 3, 4);
    chk("t3_acks0", ack_cnt0 - a0, 3);
    chk("t3_acks1_blocked", ack_cnt1 - a1, 0);
    tick();
    serve(1, 1, 5);
    chk("t3_acks1", ack_cnt1 - a1, 1);

    // Reset during WAIT aborts without a done pulse
    req_in_ready = 2'b10;
    tick();
    chk("t4_clear_grant", grant, 2'b10);
    tick();
    req_last = 2'b10;
    req_in[RATE +: RATE] = blk(1, 9);
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    req_in_ready = 2'b00;
    req_last = 2'b00;
    tick();
    core_out = cst(6);
    core_out_ready = 1'b1;
    d0 = done_cnt0; d1 = done_cnt1;
    reset = 1'b0;
    #1;
    chk("t4_rst_grant", grant, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_core_reset", core_reset, 1);
    chk("t4_rst_dout", dout, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t4_post_core_reset", core_reset, 1);
    core_out_ready = 1'b0;
    tick();
    chk("t4_idle_core_reset", core_reset, 0);
    chk("t4_idle_grant", grant, 0);
    chk("t4_no_done", (done_cnt0 - d0) + (done_cnt1 - d1), 0);

    // Back-to-back messages from requester 1, each with its own CLEAR
    req_in_ready = 2'b10;
    tick();
    serve(1, 2, 7);
    chk("t5_gap_core_reset", core_reset, 0);
    req_in_ready = 2'b10;
    tick();
    serve(1, 1, 8);

`ifdef PERM_ARB_TIMEOUT_EN
    // Starved grant released after 8 idle ABSORB cycles
    d0 = done_cnt0;
    req_in_ready = 2'b01;
    tick();
    chk("to_grant", grant, 2'b01);
    tick();
    req_in_ready = 2'b00;
    repeat (7) tick();
    chk("to_held", grant, 2'b01);
    chk("to_not_yet", timeout, 0);
    tick();
    chk("to_release", grant, 0);
    chk("to_pulse", timeout, 2'b01);
    tick();
    chk("to_pulse_end", timeout, 0);
    chk("to_no_done", done_cnt0 - d0, 0);
    req_in_ready = 2'b01;
    tick();
    chk("to_next_clear", core_reset, 1);
    chk("to_next_grant", grant, 2'b01);
    req_in_ready = 2'b00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perm_arbiter.md
PERM_ARBITER -- requirements
Module: perm_arbiter

Interface
REQ-001 SHALL have parameter RATE, default 576, meaning absorb block width in bits.
REQ-002 SHALL have parameter DIGEST_W, default 512, meaning the digest width taken from core_out[1599:1600-DIGEST_W].
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the idle-cycle limit for the watchdog.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_in  input  2*RATE  message blocks; requester k drives bits [k*RATE +: RATE].
REQ-007 SHALL have port req_in_ready  input  2  block-valid flag per requester.
REQ-008 SHALL have port req_last  input  2  per-requester flag: the current block is the final padded block.
REQ-009 SHALL have port req_ack  output  2  per-requester flag: the block was consumed this cycle.
REQ-010 SHALL have port grant  output  2  one-hot owner of the core, or zero.
REQ-011 SHALL have port done  output  2  one-cycle pulse per requester: digest valid.
REQ-012 SHALL have port dout  output  DIGEST_W  the registered digest.
REQ-013 SHALL have port core_reset  output  1  synchronous clear to the permutation core, active-high.
REQ-014 SHALL have port core_in  output  RATE  block forwarded to the core.
REQ-015 SHALL have port core_in_ready  output  1  block-valid flag forwarded to the core.
REQ-016 SHALL have port core_ack  input  1  the core accepted the block.
REQ-017 SHALL have port core_out  input  1600  the core state.
REQ-018 SHALL have port core_out_ready  input  1  the core finished its 24 rounds.

Function
REQ-019 SHALL implement states IDLE, CLEAR, ABSORB, WAIT, DONE.
REQ-020 IDLE: SHALL stay in IDLE while req_in_ready==0. When any bit is set, SHALL register a grant and move to CLEAR on the next edge.
REQ-021 Arbitration SHALL be round-robin. With both requesters requesting, the grant SHALL go to the requester not served last. After reset, requester 0 SHALL have priority.
REQ-022 CLEAR: SHALL assert core_reset=1 for exactly one cycle, then move to ABSORB.
REQ-023 ABSORB: SHALL drive core_in=req_in[g] and core_in_ready=req_in_ready[g] combinationally; SHALL drive req_ack[g]=core_ack.
REQ-024 The ungranted requester SHALL always see req_ack=0. core_in_ready SHALL be 0 outside ABSORB.
REQ-025 On core_ack with req_last[g]=1, SHALL move to WAIT. On core_ack with req_last[g]=0, SHALL stay in ABSORB.
REQ-026 WAIT: SHALL ignore core_out_ready in the cycle immediately after the accepting edge. On the first later cycle with core_out_ready=1, SHALL load dout and move to DONE.
REQ-027 DONE: SHALL pulse done[g] for one cycle, update the round-robin pointer, clear grant, and return to IDLE.
REQ-028 dout SHALL hold its value until the next DONE.
REQ-029 Latency: a request first seen in IDLE at cycle t SHALL produce core_reset at t+1 and the earliest core_in_ready at t+2.
REQ-030 A requester dropping req_in_ready mid-message SHALL keep the grant.
REQ-031 grant SHALL be zero exactly in IDLE.

Reset
REQ-032 While reset==0: state=IDLE, grant=0, done=0, dout=0, core_reset=1, round-robin pointer favouring requester 0.
REQ-033 Reset asserted mid-operation SHALL abort the message with no done pulse.
REQ-034 core_reset SHALL remain 1 for the first cycle after reset deasserts.

Configuration
REQ-035 With macro PERM_ARB_TIMEOUT_EN defined, SHALL count consecutive ABSORB cycles with req_in_ready[g]==0. On reaching TIMEOUT, SHALL release the grant without a done pulse and return to IDLE; the next message SHALL pass through CLEAR.
REQ-036 With PERM_ARB_TIMEOUT_EN defined, SHALL add output port timeout  output  2  one-cycle pulse to the aborted requester.
REQ-037 Without PERM_ARB_TIMEOUT_EN, SHALL have no counter and no timeout port; a grant SHALL be held indefinitely.

Structure
REQ-038 SHALL place the state enum typedef and constants WIDTH=1600 and ROUNDS=24 in shared package keccak_arb_pkg.
REQ-039 SHALL place round-robin grant selection in sub-module rr_arb2 (2 requests, a pointer, one-hot grant out).

Verification
REQ-040 Single requester 0, one block with last=1 -> core_reset pulse at t+1, ack once, done[0] after 24 rounds, dout=top 512 bits of core_out.
REQ-041 Requesters 0 and 1 request in the same cycle from reset -> grant 01 first, done[0], then grant 10, done[1].
REQ-042 Requester 0 sends 3 blocks (last on the third) while requester 1 waits -> exactly 3 acks to requester 0, req_ack[1]=0 throughout, then grant passes to requester 1.
REQ-043 reset driven low during WAIT -> grant=0, done never pulses; after release, core_reset=1 for 1 cycle and IDLE.
REQ-044 With PERM_ARB_TIMEOUT_EN and TIMEOUT=8: grant held with in_ready=0 for 8 cycles -> timeout[g] pulse, IDLE, next grant goes through CLEAR.
REQ-045 Back-to-back messages from requester 1 only -> each message gets its own CLEAR pulse, and both digests match the golden SHA3 model.
